ram_seq_ctrl: RTL and testbench
===============================

// Module: ram_seq_ctrl
// PURPOSE
//  Single-clock sequencer that owns the address/enable port of the DC RAM.
//  LOAD: accepts a valid/ready word stream and writes it to addresses 0..N-1.
//  READ: streams addresses 0..N-1 back out through a valid/ready interface,
//   hiding the RAM's 1-cycle read latency so throughput is 1 word/cycle.
//  Both RAM clocks are tied to clk in this integration.
// PARAMETERS
//  DATA_W  8  word width (= word_lenght_t)
//  ADDR_W  8  RAM address width (= ADDR_lenght_t); DEPTH = ADDR_LENGHT+1 words
// PORTS
//  clk         in   1        single clock, all logic posedge
//  rst         in   1        reset: synchronous, active-low
//  load_start  in   1        pulse: begin LOAD of len words
//  read_start  in   1        pulse: begin READ of len words
//  len         in   ADDR_W+1 word count, sampled on accepted start
//  in_data     in   DATA_W   LOAD stream data
//  in_valid    in   1        LOAD stream valid
//  in_ready    out  1        LOAD stream ready
//  out_data    out  DATA_W   READ stream data
//  out_valid   out  1        READ stream valid
//  out_ready   in   1        READ stream ready (backpressure)
//  busy        out  1        1 while not IDLE
//  done        out  1        1-cycle pulse at end of LOAD or READ
//  ram_addr    out  ADDR_W   RAM ADDR
//  ram_we      out  1        RAM ENABLE_W
//  ram_re      out  1        RAM ENABLE_R
//  ram_wdata   out  DATA_W   RAM Data_IN
//  ram_rdata   in   DATA_W   RAM DATA_OUT (valid 1 cycle after ram_re)
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE; counters, buffer, in-flight flag cleared;
//   all outputs 0. Reset mid-LOAD/READ aborts; no done pulse.
//  FSM: IDLE -> LOAD (load_start) | READ (read_start); both high -> LOAD wins.
//   Start while busy is ignored. len latched as min(len, DEPTH).
//  len==0: enter FINISH directly; done pulses the next cycle, no RAM access.
//  LOAD: in_ready=1. On in_valid&in_ready: ram_we=1, ram_addr=wcnt, ram_wdata=in_data,
//   same cycle (combinational); wcnt++. After last word -> FINISH.
//  READ: issue ram_re with ram_addr=rcnt when rcnt<len and
//   (buf_count + inflight - pop) < 2; rcnt++. inflight set for one cycle;
//   next cycle ram_rdata pushed into 2-entry output buffer. ram_rdata is ignored
//   on any cycle not following ram_re (RAM returns 0 then).
//  out_valid = buffer non-empty; out_data = head; pop on out_valid&out_ready.
//   First word at the output 2 cycles after read_start accepted; with out_ready
//   held 1, one word/cycle thereafter. Order strictly addresses 0..N-1.
//  READ -> FINISH when all N words issued, none in flight, buffer empty.
//  FINISH: done=1 for one cycle, -> IDLE. busy=0 only in IDLE.
//  ram_we and ram_re never high in the same cycle; ram_addr=0 when both low.
//  Counters are ADDR_W+1 bits; address = counter[ADDR_W-1:0]; no wrap (clamped).
// STRUCTURE
//  Definitions_Package: word_lenght_t, ADDR_lenght_t, ADDR_LENGHT, and the
//   state enum seq_state_t {IDLE, LOAD, READ, FINISH}.
//  Sub-module seq_out_buf: 2-entry FIFO (push/pop same cycle allowed, count out).
// TESTING
//  Reset: drive traffic, assert rst=0 mid-READ -> next cycle busy=0, out_valid=0,
//   ram_re=0, no done.
//  LOAD len=4, data 8'hA1..A4 back-to-back -> ram_we on 4 cycles at addr 0..3,
//   done 1 cycle after last write.
//  READ len=4, out_ready=1 after above -> out_data A1,A2,A3,A4 on 4 consecutive
//   cycles starting 2 cycles after read_start, then done.
//  READ len=4, out_ready toggling 1,0,0,1,... -> no loss/duplication; ram_re
//   stalls while buffer+in-flight = 2.
//  len=0 and len=DEPTH+5 -> done with no access; clamped full-depth transfer.
//  load_start and read_start same cycle -> LOAD entered; start during busy ignored.

Source files
------------

// File: rtl/ram_seq_ctrl_pkg.sv
// Shared widths, RAM geometry and sequencer state encoding for ram_seq_ctrl.
package ram_seq_ctrl_pkg;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int ADDR_LENGHT = (1 << DEF_ADDR_W) - 1;
    localparam int DEPTH       = ADDR_LENGHT + 1;

    typedef logic [DEF_DATA_W-1:0] word_lenght_t;
    typedef logic [DEF_ADDR_W-1:0] ADDR_lenght_t;
    typedef logic [1:0]            buf_cnt_t;

    typedef enum logic [1:0] {IDLE, LOAD, READ, FINISH} seq_state_t;
endpackage

// File: rtl/ram_seq_ctrl_out_buf.sv
// Two-entry output FIFO that absorbs RAM read latency; push and pop may coincide.
module seq_out_buf
    import ram_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output buf_cnt_t          count
);
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + buf_cnt_t'(push) - buf_cnt_t'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/ram_seq_ctrl.sv
// Sequencer owning the DC RAM port: streams words in (LOAD) or out (READ)
// over addresses 0..N-1 at one word per cycle.
module ram_seq_ctrl
    import ram_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              read_start,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    seq_state_t        state;
    logic [ADDR_W:0]   wcnt, rcnt, len_q, len_c;
    logic              inflight;
    logic              wr_fire, rd_fire, pop;
    logic [2:0]        occ;
    buf_cnt_t          buf_count;
    logic [DATA_W-1:0] buf_head;

    always_comb begin
        len_c     = (len > DEPTH_V) ? DEPTH_V : len;
        wr_fire   = (state == LOAD) && in_valid && in_ready;
        pop       = out_valid && out_ready;
        // Occupancy after this cycle's pop; the word in flight already owns a slot.
        occ       = 3'(buf_count) + 3'(inflight) - 3'(pop);
        rd_fire   = (state == READ) && (rcnt < len_q) && (occ < 3'd2);
        ram_we    = wr_fire;
        ram_re    = rd_fire;
        ram_addr  = wr_fire ? wcnt[ADDR_W-1:0] : (rd_fire ? rcnt[ADDR_W-1:0] : '0);
        ram_wdata = wr_fire ? in_data : '0;
    end

    assign out_valid = (buf_count != '0);
    assign out_data  = out_valid ? buf_head : '0;

    seq_out_buf #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (ram_rdata),
        .pop       (pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            wcnt     <= '0;
            rcnt     <= '0;
            len_q    <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            inflight <= rd_fire;
            done     <= 1'b0;
            case (state)
                IDLE: if (load_start || read_start) begin
                    len_q <= len_c;
                    wcnt  <= '0;
                    rcnt  <= '0;
                    busy  <= 1'b1;
                    if (len_c == '0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else if (load_start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                LOAD: if (wr_fire) begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt + 1'b1 == len_q) begin
                        state    <= FINISH;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_fire)
                        rcnt <= rcnt + 1'b1;
                    if (rcnt == len_q && !inflight && buf_count == '0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Randomized bench for ram_seq_ctrl: behavioural RAM, reference memory image
// and a negedge monitor checking every RAM access and output word.
module tb_ram_seq_ctrl;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_start = 1'b0, read_start = 1'b0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready = 1'b0;
    logic          busy, done;
    logic [AW-1:0] ram_addr;
    logic          ram_we, ram_re;
    logic [DW-1:0] ram_wdata, ram_rdata = '0;

    always #5 clk = ~clk;

    ram_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .read_start(read_start),
        .len(len), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_re(ram_re), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural RAM: 1-cycle read latency, returns 0 when not read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram_re ? ram[ram_addr] : '0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Owned by the stimulus process.
    logic [DW-1:0] ld_words [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    int errors = 0, checks = 0;
    int xfer_id = 0, rd_start = 0;
    bit rd_timed = 0;

    // Owned by the monitor.
    int mon_errors = 0, mon_checks = 0, seen_id = 0;
    int wi = 0, ii = 0, ri = 0, outst = 0;
    int mon_n_wr = 0, mon_n_iss = 0, mon_n_rd = 0, mon_n_done = 0, mon_stalls = 0;
    int last_wr_cyc = 0, last_rd_cyc = 0, done_cyc = 0;
    bit mpop;

    always @(negedge clk) begin
        if (rst) begin
            if (xfer_id != seen_id) begin
                seen_id = xfer_id; wi = 0; ii = 0; ri = 0;
            end
            outst = ii - ri;
            mpop  = out_valid && out_ready;
            mon_checks++;
            if (ram_we && ram_re) begin
                mon_errors++;
                $display("FAIL we_re_exclusive: we=%0b re=%0b, required not both", ram_we, ram_re);
            end
            if (!ram_we && !ram_re) begin
                mon_checks++;
                if (ram_addr !== '0) begin
                    mon_errors++;
                    $display("FAIL idle_addr: addr=%0d, required 0", ram_addr);
                end
            end
            mon_checks++;
            if (outst > 2 || (ram_re && (outst - int'(mpop)) >= 2)) begin
                mon_errors++;
                $display("FAIL occupancy: outstanding=%0d re=%0b pop=%0b, required re=0 at 2", outst, ram_re, mpop);
            end
            if (busy && !ram_re && (outst - int'(mpop)) >= 2) mon_stalls++;
            if (ram_we) begin
                mon_checks++;
                if (wi >= DEPTH || ram_addr !== AW'(wi) || ram_wdata !== ld_words[wi[AW-1:0]]
                    || !(in_valid && in_ready)) begin
                    mon_errors++;
                    $display("FAIL write: addr=%0d data=%0h, required addr=%0d data=%0h",
                             ram_addr, ram_wdata, wi, ld_words[wi[AW-1:0]]);
                end
                wi++; mon_n_wr++; last_wr_cyc = cyc;
            end
            if (ram_re) begin
                mon_checks++;
                if (ram_addr !== AW'(ii)) begin
                    mon_errors++;
                    $display("FAIL read_addr: addr=%0d, required %0d", ram_addr, ii);
                end
                ii++; mon_n_iss++;
            end
            if (mpop) begin
                mon_checks++;
                if (out_data !== ref_mem[ri[AW-1:0]]) begin
                    mon_errors++;
                    $display("FAIL out_data: word %0d got %0h, required %0h", ri, out_data, ref_mem[ri[AW-1:0]]);
                end
                if (rd_timed) begin
                    // Accepted at the end of the start cycle; word k appears 3+k cycles later.
                    mon_checks++;
                    if (cyc != rd_start + 3 + ri) begin
                        mon_errors++;
                        $display("FAIL out_timing: word %0d at cycle %0d, required %0d", ri, cyc, rd_start + 3 + ri);
                    end
                end
                ri++; mon_n_rd++; last_rd_cyc = cyc;
            end
            if (done) begin
                mon_n_done++; done_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_xfer(input bit ld, input bit rd, input int n);
        len = n[AW:0]; load_start = ld; read_start = rd;
        xfer_id++; rd_start = cyc;
        tick();
        load_start = 1'b0; read_start = 1'b0;
    endtask

    task automatic drive_load(input int from, input int n, input bit gaps);
        int k = from, budget = 0;
        bit hs;
        while (k < n && budget < 8 * n + 50) begin
            in_data  = ld_words[k];
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            hs = in_valid && in_ready;
            tick();
            if (hs) k++;
            budget++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int b = 0;
        while (mon_n_done == d0 && b < budget) begin tick(); b++; end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, in_ready, out_valid, ram_we, ram_re} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: busy,done,in_ready,out_valid,we,re=%b, required 000000",
                     {busy, done, in_ready, out_valid, ram_we, ram_re});
        end
        checks++;
        if (ram_addr !== '0 || ram_wdata !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_buses: addr=%0h wdata=%0h out=%0h, required 0", ram_addr, ram_wdata, out_data);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load(input int n, input bit gaps, input bit pattern);
        int n_exp = (n > DEPTH) ? DEPTH : n;
        int d0 = mon_n_done, w0 = mon_n_wr, s;
        for (int k = 0; k < DEPTH; k++) ld_words[k] = pattern ? DW'(8'hA1 + k) : DW'($urandom);
        s = cyc;
        start_xfer(1'b1, 1'b0, n);
        if (n_exp > 0) begin
            checks++;
            if (in_ready !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL load_enter: in_ready=%0b busy=%0b, required 1 1", in_ready, busy);
            end
        end
        drive_load(0, n_exp, gaps);
        wait_done(d0, 20);
        for (int k = 0; k < n_exp; k++) ref_mem[k] = ld_words[k];
        checks++;
        if (mon_n_wr - w0 != n_exp) begin
            errors++;
            $display("FAIL load_count: len=%0d writes=%0d, required %0d", n, mon_n_wr - w0, n_exp);
        end
        checks++;
        if (mon_n_done - d0 != 1) begin
            errors++;
            $display("FAIL load_done: pulses=%0d, required 1", mon_n_done - d0);
        end
        checks++;
        if (done_cyc != ((n_exp == 0) ? s + 1 : last_wr_cyc + 1)) begin
            errors++;
            $display("FAIL load_done_cycle: done at %0d, required %0d", done_cyc,
                     (n_exp == 0) ? s + 1 : last_wr_cyc + 1);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: busy=%0b done=%0b, required 0 0", busy, done);
        end
    endtask

    // mode 0: out_ready held 1 (timed), 1: pattern 1,0,0,..., 2: random
    task automatic test_read(input int n, input int mode);
        int n_exp = (n > DEPTH) ? DEPTH : n;
        int d0 = mon_n_done, r0 = mon_n_rd, i0 = mon_n_iss, st0 = mon_stalls, b = 0;
        rd_timed  = (mode == 0);
        out_ready = (mode != 1) ? 1'b1 : 1'b0;
        start_xfer(1'b0, 1'b1, n);
        while (mon_n_done == d0 && b < 8 * n_exp + 40) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (b % 3 == 0) : 1'($urandom_range(0, 1));
            tick(); b++;
        end
        rd_timed = 1'b0;
        checks++;
        if (mon_n_rd - r0 != n_exp || mon_n_iss - i0 != n_exp) begin
            errors++;
            $display("FAIL read_count: len=%0d popped=%0d issued=%0d, required %0d",
                     n, mon_n_rd - r0, mon_n_iss - i0, n_exp);
        end
        checks++;
        if (mon_n_done - d0 != 1 || (n_exp > 0 && done_cyc <= last_rd_cyc)) begin
            errors++;
            $display("FAIL read_done: pulses=%0d at %0d last word %0d, required 1 after last word",
                     mon_n_done - d0, done_cyc, last_rd_cyc);
        end
        if (mode == 1 && n_exp >= 4) begin
            checks++;
            if (mon_stalls - st0 == 0) begin
                errors++;
                $display("FAIL read_stall: stalls=0, required >0 under backpressure");
            end
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: busy=%0b out_valid=%0b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_read();
        int d0;
        out_ready = 1'b0;
        start_xfer(1'b0, 1'b1, 8);
        repeat (4) tick();
        d0 = mon_n_done;
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || ram_re !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%0b out_valid=%0b re=%0b done=%0b, required 0",
                     busy, out_valid, ram_re, done);
        end
        rst = 1'b1;
        repeat (6) tick();
        checks++;
        if (mon_n_done != d0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: done pulses=%0d busy=%0b out_valid=%0b, required 0 0 0",
                     mon_n_done - d0, busy, out_valid);
        end
    endtask

    task automatic test_both_start();
        int d0 = mon_n_done, w0 = mon_n_wr, i0 = mon_n_iss;
        for (int k = 0; k < DEPTH; k++) ld_words[k] = DW'($urandom);
        out_ready = 1'b0;
        start_xfer(1'b1, 1'b1, 3);
        checks++;
        if (in_ready !== 1'b1 || ram_re !== 1'b0) begin
            errors++;
            $display("FAIL both_start: in_ready=%0b re=%0b, required 1 0", in_ready, ram_re);
        end
        in_data = ld_words[0]; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Starts while busy must be ignored.
        len = 9'd9; load_start = 1'b1; read_start = 1'b1;
        tick();
        load_start = 1'b0; read_start = 1'b0;
        drive_load(1, 3, 1'b1);
        wait_done(d0, 20);
        for (int k = 0; k < 3; k++) ref_mem[k] = ld_words[k];
        checks++;
        if (mon_n_wr - w0 != 3 || mon_n_iss - i0 != 0 || mon_n_done - d0 != 1) begin
            errors++;
            $display("FAIL busy_start: writes=%0d reads=%0d done=%0d, required 3 0 1",
                     mon_n_wr - w0, mon_n_iss - i0, mon_n_done - d0);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || mon_n_done - d0 != 1) begin
            errors++;
            $display("FAIL busy_start_idle: busy=%0b done=%0d, required 0 1", busy, mon_n_done - d0);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            int n = $urandom_range(1, 20);
            test_load(n, 1'b1, 1'b0);
            test_read(n, 2);
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin ram[k] = '0; ref_mem[k] = '0; ld_words[k] = '0; end
        test_reset();
        test_load(4, 1'b0, 1'b1);
        test_read(4, 0);
        test_read(4, 1);
        test_reset_mid_read();
        test_load(0, 1'b0, 1'b0);
        test_read(0, 0);
        test_load(DEPTH + 5, 1'b1, 1'b0);
        test_read(DEPTH + 5, 0);
        test_read(12, 1);
        test_both_start();
        test_read(3, 0);
        test_back_to_back();
        tick();
        errors += mon_errors;
        checks += mon_checks;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
